// File: rtl/ysyx_040066_pkg.sv
// rtl/ysyx_040066_pkg.sv - shared widths, defaults, FSM encoding and helpers for the IF stage
//
// Purpose : constants and small helpers shared by the instruction-fetch
//           stage, its interface and the PC register.
// Contents: PC_W / INST_W widths, default RESET_PC / NOP_INST values,
//           3-bit FSM state encoding, PC alignment helper.
package ysyx_040066_pkg;

   localparam int PC_W   = 64;
   localparam int INST_W = 32;

   localparam logic [PC_W-1:0]   DEF_RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0013;

   // Fetch FSM encoding, kept as plain constants so older code that
   // compares against raw 3-bit values keeps working.
   typedef logic [2:0] if_state_t;

   localparam if_state_t ST_IDLE = 3'd0;   // one cycle after reset only
   localparam if_state_t ST_REQ  = 3'd1;   // request presented to imem
   localparam if_state_t ST_WAIT = 3'd2;   // request accepted, awaiting data
   localparam if_state_t ST_FULL = 3'd3;   // instruction held for ID
   localparam if_state_t ST_DROP = 3'd4;   // awaiting a wrong-path response

   // Instructions are 4-byte aligned; redirect targets are forced onto
   // that grid rather than trusted.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_040066_ifetch_if.sv
// rtl/ysyx_040066_ifetch_if.sv - signal bundle between IF, EX redirect, imem and ID
//
// Purpose : groups the redirect input, the instruction-memory request /
//           response channels and the IF->ID handshake.
// Signals : ex_is_jmp, ex_nxtpc                   - EX redirect
//           imem_req_valid/ready, imem_addr       - fetch request
//           imem_rsp_valid, imem_rsp_data         - fetch response
//           id_valid/ready, id_pc, id_inst        - handoff to ID
// Modports: master - the fetch stage; slave - its environment.
interface ysyx_040066_ifetch_if;
   import ysyx_040066_pkg::*;

   logic              ex_is_jmp;
   logic [PC_W-1:0]   ex_nxtpc;

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;

   logic              id_valid;
   logic              id_ready;
   logic [PC_W-1:0]   id_pc;
   logic [INST_W-1:0] id_inst;

   modport master (
      input  ex_is_jmp,
      input  ex_nxtpc,
      output imem_req_valid,
      input  imem_req_ready,
      output imem_addr,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output id_valid,
      input  id_ready,
      output id_pc,
      output id_inst
   );

   modport slave (
      output ex_is_jmp,
      output ex_nxtpc,
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_addr,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  id_valid,
      output id_ready,
      input  id_pc,
      input  id_inst
   );

endinterface

// File: rtl/ysyx_040066_pc_reg.sv
// rtl/ysyx_040066_pc_reg.sv - architectural PC register with redirect mux and +4 incrementer
//
// Purpose : holds the fetch PC.
// Ports   : clk, rst       - clock, asynchronous active-high reset
//           redirect       - load the aligned target (highest priority)
//           target         - redirect target, low two bits ignored
//           advance        - step to the next sequential instruction
//           pc             - current fetch PC
module ysyx_040066_pc_reg
   import ysyx_040066_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [PC_W-1:0] target,
   input  logic            advance,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= align_pc(target);
      end else if (advance) begin
         pc <= pc + PC_W'(4);   // wraps modulo 2^64
      end
   end

endmodule

// File: rtl/ysyx_040066_ifetch.sv
// rtl/ysyx_040066_ifetch.sv - instruction-fetch stage: one outstanding imem request, {pc, inst} to ID
//
// Purpose : walks the PC, issues one imem request at a time, captures the
//           returned instruction and presents it to ID. An EX redirect
//           reloads the PC, flushes the held instruction and discards any
//           response still in flight.
// Ports   : clk, rst - clock, asynchronous active-high reset
//           bus      - ysyx_040066_ifetch_if.master (redirect, imem, ID)
// Params  : RESET_PC - PC after reset
//           NOP_INST - id_inst value while nothing is held
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module ysyx_040066_ifetch
   import ysyx_040066_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC = DEF_RESET_PC,
   parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx_040066_ifetch_if.master  bus
);

   if_state_t         state;
   if_state_t         state_nxt;
   logic [PC_W-1:0]   pc;

   logic              id_valid_q;
   logic [PC_W-1:0]   id_pc_q;
   logic [INST_W-1:0] id_inst_q;

   logic              req_hs;
   logic              rsp_seen;
   logic              capture;
   logic              id_accept;

   // Responses are only meaningful while a request is outstanding; in
   // IDLE, REQ and FULL the rsp_valid input is ignored.
   assign req_hs    = (state == ST_REQ) && bus.imem_req_ready;
   assign rsp_seen  = ((state == ST_WAIT) || (state == ST_DROP)) && bus.imem_rsp_valid;
   assign capture   = (state == ST_WAIT) && bus.imem_rsp_valid && !bus.ex_is_jmp;
   assign id_accept = (state == ST_FULL) && bus.id_ready;

   ysyx_040066_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .redirect (bus.ex_is_jmp),
      .target   (bus.ex_nxtpc),
      .advance  (capture),
      .pc       (pc)
   );

   always_comb begin
      state_nxt = state;
      if (bus.ex_is_jmp) begin
         // A redirect wins over everything. If a request is (or is about
         // to be) outstanding with no response this cycle, its data is
         // wrong-path and must be swallowed in DROP before refetching.
         case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ:  state_nxt = req_hs ? ST_DROP : ST_REQ;
            ST_WAIT: state_nxt = rsp_seen ? ST_REQ : ST_DROP;
            ST_FULL: state_nxt = ST_REQ;
            ST_DROP: state_nxt = rsp_seen ? ST_REQ : ST_DROP;
            default: state_nxt = ST_IDLE;
         endcase
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ:  state_nxt = req_hs ? ST_WAIT : ST_REQ;
            ST_WAIT: state_nxt = rsp_seen ? ST_FULL : ST_WAIT;
            ST_FULL: state_nxt = id_accept ? ST_REQ : ST_FULL;
            ST_DROP: state_nxt = rsp_seen ? ST_REQ : ST_DROP;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ID output register. id_pc keeps its last value after handoff; only
   // valid and inst are scrubbed so ID never sees a stale opcode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= NOP_INST;
      end else if (bus.ex_is_jmp) begin
         id_valid_q <= 1'b0;
         id_inst_q  <= NOP_INST;
      end else if (capture) begin
         id_valid_q <= 1'b1;
         id_pc_q    <= pc;
         id_inst_q  <= bus.imem_rsp_data;
      end else if (id_accept) begin
         id_valid_q <= 1'b0;
         id_inst_q  <= NOP_INST;
      end
   end

   assign bus.imem_req_valid = (state == ST_REQ);
   assign bus.imem_addr      = pc;
   assign bus.id_valid       = id_valid_q;
   assign bus.id_pc          = id_pc_q;
   assign bus.id_inst        = id_inst_q;

endmodule

// File: tb/tb_ysyx_040066_ifetch.sv
// tb/tb_ysyx_040066_ifetch.sv - scoreboard bench for the instruction-fetch stage
`timescale 1ns/1ps
module tb_ysyx_040066_ifetch;
   import ysyx_040066_pkg::*;

   localparam logic [63:0] RST_PC      = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP         = 32'h0000_0013;
   localparam logic [31:0] ORPHAN_WORD = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fetch_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_040066_ifetch_if bus();

   ysyx_040066_ifetch #(
      .RESET_PC (RST_PC),
      .NOP_INST (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int delivered   = 0;

   // Reference: the next instruction ID must receive. Program order is
   // pc, pc+4, ... from the last redirect target (or RESET_PC).
   fetch_t sb_q[$];

   // stimulus knobs
   int unsigned ready_pct   = 100;
   int unsigned idready_pct = 100;
   int unsigned jmp_pct     = 0;
   int unsigned junk_pct    = 0;
   int unsigned lat_min     = 1;
   int unsigned lat_max     = 1;
   int          dir_mode    = 0;     // 1: redirect in WAIT, 2: with REQ handshake, 3: in FULL
   bit          dir_done    = 1'b0;
   logic [63:0] dir_target  = '0;

   // memory model state
   bit          outst  = 1'b0;
   bit          orphan = 1'b0;
   logic [63:0] out_addr = '0;
   int unsigned lat    = 0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == RST_PC) return 32'h0010_0093;
      return a[33:2] ^ 32'h1357_9BDF;
   endfunction

   function automatic fetch_t expect_from(input logic [63:0] a);
      fetch_t f;
      f.pc   = a;
      f.inst = mem_word(a);
      return f;
   endfunction

   function automatic bit pct(input int unsigned p);
      return $urandom_range(99, 0) < p;
   endfunction

   function automatic logic [63:0] rand_target();
      case ($urandom_range(3, 0))
         0:       return {$urandom, $urandom};
         1:       return 64'h8000_0000 + 64'($urandom_range(255, 0));
         2:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
         default: return 64'($urandom_range(63, 0));
      endcase
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check64({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
      check64({tag, "_addr"},      bus.imem_addr,      RST_PC);
      check64({tag, "_id_valid"},  bus.id_valid,       1'b0);
      check64({tag, "_id_pc"},     bus.id_pc,          64'h0);
      check64({tag, "_id_inst"},   bus.id_inst,        NOP);
   endtask

   function automatic bit cond(input int what);
      case (what)
         0:       return bus.id_valid;
         1:       return bus.imem_req_valid;
         2:       return outst;
         default: return dir_done;
      endcase
   endfunction

   task automatic wait_for(input int what, input string name);
      int n = 0;
      while (!cond(what) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check64(name, cond(what), 1'b1);
   endtask

   // Stimulus and memory responder: evaluate the cycle at negedge, drive the
   // next cycle's inputs just after posedge.
   initial begin
      logic        jmp;
      logic [63:0] tgt;
      bus.ex_is_jmp      = 1'b0;
      bus.ex_nxtpc       = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.id_ready       = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.imem_rsp_valid && outst) outst = 1'b0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               check64("one_outstanding", outst, 1'b0);
               if (!bus.ex_is_jmp)
                  check64("fetch_addr", bus.imem_addr, (sb_q.size() > 0) ? sb_q[0].pc : ~bus.imem_addr);
               outst    = 1'b1;
               out_addr = bus.imem_addr;
               lat      = $urandom_range(lat_max, lat_min);
               orphan   = bus.ex_is_jmp;
            end else if (bus.ex_is_jmp && outst) begin
               orphan = 1'b1;
            end
         end
         @(posedge clk); #1;
         if (rst) begin
            bus.ex_is_jmp      = 1'b0;
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = 1'b0;
            bus.id_ready       = 1'b0;
            outst  = 1'b0;
            orphan = 1'b0;
            lat    = 0;
         end else begin
            if (outst && lat == 1) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = orphan ? ORPHAN_WORD : mem_word(out_addr);
               lat = 0;
            end else begin
               if (outst && lat > 1) lat--;
               bus.imem_rsp_valid = !outst && pct(junk_pct);
               bus.imem_rsp_data  = ORPHAN_WORD;
            end
            bus.imem_req_ready = pct(ready_pct);
            bus.id_ready       = pct(idready_pct);
            jmp = pct(jmp_pct);
            tgt = rand_target();
            if (dir_mode != 0 && !dir_done) begin
               if (dir_mode == 1 && outst && !bus.imem_rsp_valid) begin
                  jmp = 1'b1; tgt = dir_target; dir_done = 1'b1;
               end else if (dir_mode == 2 && bus.imem_req_valid) begin
                  bus.imem_req_ready = 1'b1;
                  jmp = 1'b1; tgt = dir_target; dir_done = 1'b1;
               end else if (dir_mode == 3 && bus.id_valid) begin
                  bus.id_ready = 1'b1;
                  jmp = 1'b1; tgt = dir_target; dir_done = 1'b1;
               end
            end
            bus.ex_is_jmp = jmp;
            bus.ex_nxtpc  = jmp ? tgt : {$urandom, $urandom};
            if (jmp) begin
               sb_q.delete();
               sb_q.push_back(expect_from({tgt[63:2], 2'b00}));
            end
         end
      end
   end

   // Monitor: compares every ID handoff against the scoreboard and checks
   // hold / flush behaviour of the ID register.
   bit          prev_hold  = 1'b0;
   bit          prev_clear = 1'b0;
   logic [63:0] prev_pc    = '0;
   logic [31:0] prev_inst  = '0;

   initial begin
      fetch_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_hold  = 1'b0;
            prev_clear = 1'b0;
         end else begin
            if (prev_hold) begin
               check64("hold_valid", bus.id_valid, 1'b1);
               check64("hold_pc", bus.id_pc, prev_pc);
               check64("hold_inst", bus.id_inst, prev_inst);
               check64("hold_no_req", bus.imem_req_valid, 1'b0);
            end
            if (prev_clear) begin
               check64("clear_valid", bus.id_valid, 1'b0);
               check64("clear_inst", bus.id_inst, NOP);
            end
            if (!bus.id_valid) check64("idle_nop", bus.id_inst, NOP);
            if (bus.id_valid && bus.id_ready && !bus.ex_is_jmp) begin
               if (sb_q.size() == 0) begin
                  check64("sb_nonempty", 64'(sb_q.size()), 64'd1);
               end else begin
                  e = sb_q.pop_front();
                  check64("id_pc", bus.id_pc, e.pc);
                  check64("id_inst", bus.id_inst, e.inst);
                  sb_q.push_back(expect_from(e.pc + 64'd4));
                  delivered++;
               end
            end
            prev_hold  = bus.id_valid && !bus.id_ready && !bus.ex_is_jmp;
            prev_clear = bus.ex_is_jmp || (bus.id_valid && bus.id_ready);
            prev_pc    = bus.id_pc;
            prev_inst  = bus.id_inst;
         end
      end
   end

   task automatic redirect(input int mode, input logic [63:0] tgt, input string name);
      @(negedge clk);
      lat_min = 2; lat_max = 2;
      dir_target = tgt;
      dir_done = 1'b0;
      dir_mode = mode;
      wait_for(3, {name, "_fired"});
      @(negedge clk);
      dir_mode = 0;
      @(posedge clk); #1;
      wait_for(0, {name, "_valid"});
      check64({name, "_pc"}, bus.id_pc, {tgt[63:2], 2'b00});
   endtask

   initial begin
      logic [63:0] held_pc;
      logic [31:0] held_inst;

      #12;
      check_reset("reset");
      sb_q.delete();
      sb_q.push_back(expect_from(RST_PC));
      @(negedge clk);
      rst = 1'b0;
      #1 check64("req_before_edge", bus.imem_req_valid, 1'b0);
      @(posedge clk); #1;
      check64("req_after_reset", bus.imem_req_valid, 1'b1);

      // first fetch, zero-wait memory
      wait_for(0, "first_valid");
      check64("first_pc", bus.id_pc, RST_PC);
      check64("first_inst", bus.id_inst, 32'h0010_0093);

      // backpressure
      @(negedge clk);
      idready_pct = 0;
      @(posedge clk); #1;
      wait_for(0, "bp_valid");
      held_pc   = bus.id_pc;
      held_inst = bus.id_inst;
      repeat (5) begin
         @(posedge clk); #1;
         check64("bp_pc", bus.id_pc, held_pc);
         check64("bp_inst", bus.id_inst, held_inst);
         check64("bp_no_req", bus.imem_req_valid, 1'b0);
      end
      @(negedge clk);
      idready_pct = 100;
      wait_for(1, "bp_req");
      check64("bp_next_addr", bus.imem_addr, held_pc + 64'd4);

      // redirects in WAIT, with REQ handshake, in FULL, and across the wrap
      redirect(1, 64'h0000_0000_8000_0100, "jmp_wait");
      redirect(2, 64'h0000_0000_8000_0102, "jmp_req_hs");
      redirect(3, 64'h0000_0000_8000_0200, "jmp_full");
      redirect(1, 64'hFFFF_FFFF_FFFF_FFFE, "jmp_wrap");
      wait_for(1, "wrap_req");
      check64("wrap_addr", bus.imem_addr, 64'h0);

      // randomized traffic
      @(negedge clk);
      lat_min = 1; lat_max = 4;
      ready_pct = 70; idready_pct = 60; jmp_pct = 8; junk_pct = 25;
      repeat (3000) @(posedge clk);
      @(negedge clk);
      jmp_pct = 0;
      repeat (40) @(posedge clk);
      check64("progress", delivered > 100, 1'b1);

      // asynchronous reset while a request is outstanding
      @(negedge clk);
      lat_min = 3; lat_max = 3; ready_pct = 100; junk_pct = 0;
      wait_for(2, "async_wait");
      #2 rst = 1'b1;
      #1 check_reset("async");
      @(posedge clk); #1;
      sb_q.delete();
      sb_q.push_back(expect_from(RST_PC));
      @(negedge clk);
      rst = 1'b0;
      lat_min = 1; lat_max = 2; idready_pct = 80;
      @(posedge clk); #1;
      wait_for(0, "restart_valid");
      check64("restart_pc", bus.id_pc, RST_PC);
      repeat (100) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
